// File: rtl/uart_pkg.sv
// Shared types and defaults for the 8N1 UART receive path.
// Timing defaults assume a 50 MHz system clock at 115200 baud.
package uart_pkg;

    localparam int UART_CLKS_PER_BIT = 434;
    localparam int UART_DATA_BITS    = 8;
    localparam int UART_NUM_BYTES    = 5;
    localparam int UART_GAP_CLKS     = 4340;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } rx_state_e;

endpackage

// File: rtl/uart_byte_rx.sv
// Single-byte 8N1 receiver: input synchronizer, mid-bit sampling FSM and shift register.
// Emits one-cycle byte_valid / byte_err strobes on the stop-bit sample cycle.
module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic                      sys_clk,
    input  logic                      rst,
    input  logic                      uart_rx,
    output logic [UART_DATA_BITS-1:0] byte_data,
    output logic                      byte_valid,
    output logic                      byte_err,
    output logic                      busy
);

    localparam int                   CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]     HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]     BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam int                   IDX_W     = $clog2(UART_DATA_BITS);
    localparam logic [IDX_W-1:0]     IDX_LAST  = IDX_W'(UART_DATA_BITS - 1);

    logic                      sync1_q;
    logic                      rx_s_q;
    rx_state_e                 state_q,     state_d;
    logic [CNT_W-1:0]          cnt_q,       cnt_d;
    logic [IDX_W-1:0]          bit_idx_q,   bit_idx_d;
    logic [UART_DATA_BITS-1:0] shift_q,     shift_d;
    logic                      stop_wait_q, stop_wait_d;

    // The line idles high, so the synchronizer resets to 1 to avoid a false start.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make every flop sample pre-edge values, so
            // the two synchronizer stages stay two distinct registers.
            sync1_q <= uart_rx;
            rx_s_q  <= sync1_q;
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            stop_wait_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            stop_wait_q <= stop_wait_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first; a path that skipped
        // an assignment would otherwise infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        stop_wait_d = stop_wait_q;
        byte_valid  = 1'b0;
        byte_err    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Counter holds the cycle index since start detection (detection cycle = 0).
                cnt_d = '0;
                if (!rx_s_q) begin
                    state_d = ST_START;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_START: begin
                if (cnt_q == HALF_LAST) begin
                    if (rx_s_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d   = ST_DATA;
                        cnt_d     = '0;
                        bit_idx_d = '0;
                    end
                end
            end
            ST_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[UART_DATA_BITS-1:1]};
                    if (bit_idx_q == IDX_LAST) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (stop_wait_q) begin
                    // Broken frame: hold off until the line returns to idle.
                    if (rx_s_q) begin
                        state_d     = ST_IDLE;
                        stop_wait_d = 1'b0;
                    end
                end else if (cnt_q == BIT_LAST) begin
                    if (rx_s_q) begin
                        byte_valid = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        byte_err    = 1'b1;
                        stop_wait_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign byte_data = shift_q;
    assign busy      = (state_q != ST_IDLE) || !rx_s_q;

endmodule

// File: rtl/uart_frame_rx.sv
// Reassembles NUM_BYTES consecutive UART bytes into one word, first byte in the MSBs.
// Partial words are dropped on a framing error or after GAP_CLKS idle cycles.
module uart_frame_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int NUM_BYTES    = UART_NUM_BYTES,
    parameter int GAP_CLKS     = UART_GAP_CLKS
) (
    input  logic                              sys_clk,
    input  logic                              rst,
    input  logic                              uart_rx,
    output logic [UART_DATA_BITS*NUM_BYTES-1:0] data,
    output logic                              data_valid,
    output logic                              frame_err,
    output logic                              busy
);

    localparam int               WORD_W    = UART_DATA_BITS * NUM_BYTES;
    localparam int               BCNT_W    = $clog2(NUM_BYTES + 1);
    localparam logic [BCNT_W-1:0] BYTE_LAST = BCNT_W'(NUM_BYTES - 1);
    localparam int               GAP_W     = $clog2(GAP_CLKS + 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CLKS - 1);

    logic [UART_DATA_BITS-1:0] byte_data;
    logic                      byte_valid;
    logic                      byte_err;
    logic                      byte_busy;

    logic [WORD_W-1:0] acc_q,        acc_d;
    logic [BCNT_W-1:0] byte_cnt_q,   byte_cnt_d;
    logic [GAP_W-1:0]  gap_q,        gap_d;
    logic [WORD_W-1:0] data_q,       data_d;
    logic              data_valid_q, data_valid_d;
    logic              frame_err_q,  frame_err_d;

    uart_byte_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_byte_rx (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .uart_rx    (uart_rx),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_err   (byte_err),
        .busy       (byte_busy)
    );

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            acc_q        <= '0;
            byte_cnt_q   <= '0;
            gap_q        <= '0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            byte_cnt_q   <= byte_cnt_d;
            gap_q        <= gap_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    always_comb begin
        acc_d        = acc_q;
        byte_cnt_d   = byte_cnt_q;
        gap_d        = gap_q;
        data_d       = data_q;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;

        // busy covers the start-detection cycle, so a start always beats a same-cycle timeout.
        if (byte_busy) begin
            gap_d = '0;
        end else if (byte_cnt_q != '0) begin
            if (gap_q == GAP_LAST) begin
                gap_d      = '0;
                byte_cnt_d = '0;
                acc_d      = '0;
            end else begin
                gap_d = gap_q + 1'b1;
            end
        end

        if (byte_valid) begin
            acc_d = {acc_q[WORD_W-UART_DATA_BITS-1:0], byte_data};
            if (byte_cnt_q == BYTE_LAST) begin
                data_d       = acc_d;
                data_valid_d = 1'b1;
                byte_cnt_d   = '0;
            end else begin
                byte_cnt_d = byte_cnt_q + 1'b1;
            end
        end

        if (byte_err) begin
            acc_d       = '0;
            byte_cnt_d  = '0;
            frame_err_d = 1'b1;
        end
    end

    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign busy       = byte_busy;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Scoreboard bench for uart_frame_rx: stimulus pushes expected words/errors with their
// expected cycle, an independent monitor pops and compares whenever the DUT strobes.
module tb_uart_frame_rx;

    localparam int CPB  = 52;          // shortened bit time keeps the run short
    localparam int NB   = 5;
    localparam int GAP  = 10 * CPB;
    localparam int HALF = CPB / 2;
    // Start edge driven at a negedge after cycle N: rx_s low at N+2, stop sample at
    // N+2+HALF-1+9*CPB, registered strobe visible one cycle later.
    localparam int STROBE_LAT = 2 + HALF + 9 * CPB;

    logic        sys_clk = 1'b0;
    logic        rst;
    logic        uart_rx;
    logic [39:0] data;
    logic        data_valid;
    logic        frame_err;
    logic        busy;

    uart_frame_rx #(
        .CLKS_PER_BIT (CPB),
        .NUM_BYTES    (NB),
        .GAP_CLKS     (GAP)
    ) dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .uart_rx    (uart_rx),
        .data       (data),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #10 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc++;

    typedef struct {
        logic [39:0] word;
        int          at;
    } exp_t;

    exp_t        exp_q[$];
    int          err_q[$];
    logic [7:0]  model_bytes[$];
    logic [39:0] last_word = '0;
    int          total = 0;
    int          bad   = 0;
    int          words_expected = 0;
    int          errs_expected  = 0;
    int          words_seen     = 0;
    int          errs_seen      = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a list of received bytes; five of them form a word, MSB first.
    task automatic model_good_byte(input logic [7:0] b, input int start_cyc);
        logic [39:0] w;
        model_bytes.push_back(b);
        if (model_bytes.size() == NB) begin
            w = '0;
            for (int i = 0; i < NB; i++)
                w = w | (40'(model_bytes[i]) << (8 * (NB - 1 - i)));
            exp_q.push_back('{word: w, at: start_cyc + STROBE_LAT});
            last_word = w;
            words_expected++;
            model_bytes.delete();
        end
    endtask

    task automatic model_bad_byte(input int start_cyc);
        err_q.push_back(start_cyc + STROBE_LAT);
        errs_expected++;
        model_bytes.delete();
    endtask

    task automatic drive(input logic v, input int n);
        uart_rx = v;
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int gap);
        int n;
        n = cyc;
        if (stop_ok) model_good_byte(b, n);
        else         model_bad_byte(n);
        drive(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive(b[i], CPB);
        drive(stop_ok, CPB);
        drive(1'b1, gap);
    endtask

    // Only ever called with short gaps or gaps well beyond GAP.
    task automatic idle_line(input int n);
        drive(1'b1, n);
        if (n >= GAP) model_bytes.delete();
    endtask

    task automatic send_word(input logic [39:0] w, input int max_gap);
        for (int i = NB - 1; i >= 0; i--)
            send_byte(w[8*i +: 8], 1'b1, (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap)));
    endtask

    task automatic glitch(input int len);
        int hi;
        hi = 0;
        uart_rx = 1'b0;
        for (int i = 1; i <= 2 * CPB; i++) begin
            @(negedge sys_clk);
            if (busy) hi++;
            if (i == len) uart_rx = 1'b1;
        end
        check("glitch_busy_cycles", 64'(hi), 64'(HALF));
    endtask

    // Monitor: pops the scoreboard whenever the DUT strobes.
    logic prev_valid = 1'b0;
    logic prev_err   = 1'b0;
    exp_t e;
    int   ea;

    always @(negedge sys_clk) begin
        if (!rst) begin
            if (prev_valid) check("data_valid_width", 64'(data_valid), 64'd0);
            if (prev_err)   check("frame_err_width", 64'(frame_err), 64'd0);
            if (data_valid) begin
                words_seen++;
                if (exp_q.size() == 0) begin
                    check("unexpected_data_valid", 64'(data), 64'hdead);
                end else begin
                    e = exp_q.pop_front();
                    check("data_word", 64'(data), 64'(e.word));
                    check("data_valid_cycle", 64'(cyc), 64'(e.at));
                end
            end
            if (frame_err) begin
                errs_seen++;
                if (err_q.size() == 0) begin
                    check("unexpected_frame_err", 64'(cyc), 64'hdead);
                end else begin
                    ea = err_q.pop_front();
                    check("frame_err_cycle", 64'(cyc), 64'(ea));
                end
            end
        end
        prev_valid = data_valid;
        prev_err   = frame_err;
    end

    initial begin
        repeat (90000) @(posedge sys_clk);
        $display("FAIL watchdog: cycle budget exhausted at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [39:0] w;
        rst     = 1'b1;
        uart_rx = 1'b1;
        repeat (3) @(negedge sys_clk);
        check("reset_data", 64'(data), 64'd0);
        check("reset_data_valid", 64'(data_valid), 64'd0);
        check("reset_frame_err", 64'(frame_err), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        idle_line(2 * CPB);

        // Transmitter loopback pattern and back-to-back bytes.
        send_word(40'h10_08_04_02_01, 0);
        idle_line(2 * CPB);
        send_word(40'hA5_5A_FF_00_3C, 0);
        idle_line(2 * CPB);

        // Short low glitches on an idle line.
        for (int g = 0; g < 3; g++) begin
            glitch(int'($urandom_range(3, HALF - 4)));
            idle_line(CPB);
        end

        // Third byte with a broken stop bit, then a clean word.
        send_byte(8'($urandom), 1'b1, 0);
        send_byte(8'($urandom), 1'b1, 0);
        send_byte(8'($urandom), 1'b0, CPB);
        send_word(40'h11_22_33_44_55, 0);
        idle_line(2 * CPB);

        // Two bytes, long silence, then a full word.
        send_byte(8'($urandom), 1'b1, 0);
        send_byte(8'($urandom), 1'b1, 0);
        idle_line(GAP + 2 * CPB);
        send_word(40'h01_02_03_04_05, 0);
        idle_line(2 * CPB);

        // Random words with random short inter-byte gaps.
        for (int k = 0; k < 3; k++) begin
            w = {8'($urandom), 32'($urandom)};
            send_word(w, 3 * CPB);
        end
        idle_line(2 * CPB);

        // Reset in the middle of the fourth byte.
        for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b1, 0);
        drive(1'b0, 3 * CPB);
        check("data_before_reset", 64'(data), 64'(last_word));
        rst = 1'b1;
        #1;
        check("midframe_reset_data", 64'(data), 64'd0);
        check("midframe_reset_valid", 64'(data_valid), 64'd0);
        check("midframe_reset_err", 64'(frame_err), 64'd0);
        check("midframe_reset_busy", 64'(busy), 64'd0);
        model_bytes.delete();
        last_word = '0;
        uart_rx = 1'b1;
        repeat (5) @(negedge sys_clk);
        rst = 1'b0;
        idle_line(2 * CPB);
        w = {8'($urandom), 32'($urandom)};
        send_word(w, 0);
        idle_line(3 * CPB);

        check("pending_words", 64'(exp_q.size()), 64'd0);
        check("pending_errors", 64'(err_q.size()), 64'd0);
        check("word_count", 64'(words_seen), 64'(words_expected));
        check("error_count", 64'(errs_seen), 64'(errs_expected));
        check("final_data", 64'(data), 64'(last_word));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_frame_rx.md
# uart_frame_rx

Receive-side counterpart of the 40-bit UART frame transmitter. Samples a serial 8N1 line at 115200 baud from a 50 MHz `sys_clk` and reassembles five consecutive bytes into one 40-bit word. Presents the word with a single-cycle valid strobe, so a loopback of the transmitter's `uart_tx` reproduces its `Data` input. Sits directly downstream of the transmitter, on the line side of the board, or in loopback benches.

## Interface
- `CLKS_PER_BIT`, 434: `sys_clk` cycles per bit (50 MHz / 115200).
- `NUM_BYTES`, 5: bytes per word; word width is 8*NUM_BYTES.
- `GAP_CLKS`, 4340: idle cycles after a byte before a partial word is discarded.
- `sys_clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `uart_rx`  in  1  serial line, idle high, asynchronous to `sys_clk`.
- `data`  out  40  last complete word; first received byte in [39:32], last in [7:0].
- `data_valid`  out  1  one-cycle pulse when `data` updates.
- `frame_err`  out  1  one-cycle pulse on bad stop bit.
- `busy`  out  1  high from start-bit detection until the byte's stop bit is resolved.

## Operation
- `uart_rx` passes through a 2-FF synchronizer. Both flops reset to 1. All logic uses the synchronized value `rx_s`.
- Bit FSM states are IDLE, START, DATA, STOP.
- IDLE: when `rx_s`=0, go to START and clear the bit counter.
- START: at counter = CLKS_PER_BIT/2−1 (216), sample `rx_s`.
  - If 1: treat as a glitch and return to IDLE. No error is raised.
  - If 0: restart the counter and go to DATA.
- DATA: sample every CLKS_PER_BIT cycles. Bits arrive LSB first into a shift register. After 8 samples, go to STOP.
- STOP: sample at the next mid-bit point.
  - If 1: the byte is good. Return to IDLE at that same cycle, so a back-to-back start bit is caught.
  - If 0: pulse `frame_err`, clear the word assembly (byte count 0, partial word dropped), and remain in STOP until `rx_s`=1, then go to IDLE.
- Word assembly on each good byte:
  - Shift the byte into the 40-bit accumulator from the right and increment the byte count.
  - When the count reaches NUM_BYTES: copy the accumulator to `data`, pulse `data_valid`, and clear the count.
- Gap timeout: a gap counter runs in IDLE while 0 < byte count < NUM_BYTES. On reaching GAP_CLKS, clear the byte count silently. Any start detection clears the gap counter.

## Timing
- Reset values: `data`=0, `data_valid`=0, `frame_err`=0, `busy`=0, FSM=IDLE, byte count=0, synchronizer=1.
- Let cycle 0 be the first cycle `rx_s` is seen low (2–3 cycles after the line edge).
  - Start sample: cycle 216.
  - Data bit k (k=0..7) sample: cycle 216+434·(k+1).
  - Stop sample: cycle 216+434·9 = 4122.
- `data_valid` and `frame_err` are registered and assert on the cycle after the stop sample.
- `data` changes on the same edge that `data_valid` rises, and holds until the next valid word.
- `busy` rises on cycle 0 and falls with the return to IDLE.
- Reset mid-frame aborts immediately. The partial word is lost and `data` returns to 0.
- A timeout and a start detection in the same cycle: the start wins, and the count is kept.
- Byte count wraps only via completion, timeout, or frame error. There is never an overflow past NUM_BYTES.

## Structure
- Package `uart_pkg`:
  - bit-FSM state enum;
  - default `CLKS_PER_BIT`=434;
  - `UART_DATA_BITS`=8.
- Sub-module `uart_byte_rx` contains the synchronizer, bit FSM and bit counter. It outputs `byte_data[7:0]`, `byte_valid`, `byte_err` and `busy`.
- `uart_frame_rx` instantiates it and adds the word accumulator, byte counter, gap counter and output registers.

## Test plan
- Loopback with the existing transmitter, `Data`=40'h10_08_04_02_01 → exactly one `data_valid` pulse, `data`=40'h1008040201, `frame_err` never high.
- Bench-driven bytes 0xA5,0x5A,0xFF,0x00,0x3C with no inter-byte gap → `data`=40'hA55AFF003C, one pulse.
- Low glitch of 100 cycles on an idle line → FSM returns to IDLE at cycle 216, `busy` pulse only, no outputs.
- Third byte sent with stop bit 0, then 5 good bytes 0x11..0x55 → one `frame_err` pulse, then `data`=40'h1122334455.
- Two bytes, then idle for 5000 cycles, then bytes 0x01..0x05 → the partial word is discarded, `data`=40'h0102030405.
- Assert `rst` during the 4th byte of a word → all outputs 0 at once. After release, a full 5-byte word is received correctly.
